// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spart_pkg
// Brief    : Shared constants and state encoding for the SPART baud generator.
// Revision : 1.0
// ============================================================================
package spart_pkg;

  localparam int DIV_WIDTH_DEF  = 16;
  localparam int OVERSAMPLE_DEF = 16;

  localparam logic RST_ACT = 1'b0;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/spart_baud_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : spart_baud_gen_if
// Brief    : Divisor input and tick output bundle of the baud generator.
// Revision : 1.0
// ============================================================================
interface spart_baud_gen_if #(
  parameter int DIV_WIDTH = 16
);

  logic [7:0]           dbLow;
  logic [7:0]           dbHigh;
  logic                 isReady;
  logic                 enable;
  logic                 txEnable;
  logic                 running;
  logic [DIV_WIDTH-1:0] divisor;

  modport master (
    output dbLow, dbHigh, isReady,
    input  enable, txEnable, running, divisor
  );

  modport slave (
    input  dbLow, dbHigh, isReady,
    output enable, txEnable, running, divisor
  );

endinterface
`default_nettype wire

// File: rtl/spart_reload_counter.sv
`default_nettype none
// ============================================================================
// Module   : spart_reload_counter
// Brief    : Loadable down-counter that reloads at 1; flags when the next count is 1.
// Revision : 1.0
// ============================================================================
module spart_reload_counter
  import spart_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  input  wire logic                 load,
  input  wire logic                 run,
  input  wire logic [DIV_WIDTH-1:0] value,
  output logic                      hitNext
);

  localparam logic [DIV_WIDTH-1:0] c_one = DIV_WIDTH'(1);

  logic [DIV_WIDTH-1:0] r_count;
  logic [DIV_WIDTH-1:0] w_next;

  // Reloading at 1 instead of 0 gives a period of exactly 'value' clocks.
  always_comb begin
    w_next = r_count;
    if (load) begin
      w_next = value;
    end else if (run) begin
      if (r_count == c_one) begin
        w_next = value;
      end else if (r_count != '0) begin
        w_next = r_count - c_one;
      end
    end
  end

  assign hitNext = (w_next == c_one);

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      r_count <= '0;
    end else begin
      r_count <= w_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/spart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : spart_baud_gen
// Brief    : SPART baud generator: oversample tick every divisor clocks, bit tick
//            every OVERSAMPLE oversample ticks.
// Revision : 1.0
// ============================================================================
module spart_baud_gen
  import spart_pkg::*;
#(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input wire logic        clk,
  input wire logic        rst,
  spart_baud_gen_if.slave bus
);

  localparam int               OVS_W   = $clog2(OVERSAMPLE);
  localparam logic [OVS_W-1:0] OVS_MAX = OVS_W'(OVERSAMPLE - 1);

  state_t               r_state;
  logic                 r_prevReady;
  logic                 r_enable;
  logic                 r_txEnable;
  logic                 r_running;
  logic [DIV_WIDTH-1:0] r_divisor;
  logic [OVS_W-1:0]     r_ovs;

  logic                 w_capture;
  logic                 w_newNonZero;
  logic                 w_run;
  logic                 w_runNext;
  logic                 w_hitNext;
  logic                 w_enableNext;
  logic [DIV_WIDTH-1:0] w_newDiv;
  logic [DIV_WIDTH-1:0] w_loadValue;
  logic [OVS_W-1:0]     w_ovsBase;

  assign w_capture    = bus.isReady && !r_prevReady;
  assign w_newDiv     = DIV_WIDTH'({bus.dbHigh, bus.dbLow});
  assign w_newNonZero = (w_newDiv != '0);
  assign w_run        = (r_state == ST_RUN);
  assign w_runNext    = w_capture ? w_newNonZero : w_run;
  assign w_loadValue  = w_capture ? w_newDiv : r_divisor;
  assign w_ovsBase    = w_capture ? '0 : r_ovs;
  // Outputs are registered from next-state terms so they line up with the count.
  assign w_enableNext = w_runNext && w_hitNext;

  spart_reload_counter #(
    .DIV_WIDTH (DIV_WIDTH)
  ) u_divCounter (
    .clk     (clk),
    .rst     (rst),
    .load    (w_capture),
    .run     (w_run),
    .value   (w_loadValue),
    .hitNext (w_hitNext)
  );

  always_ff @(posedge clk) begin
    if (rst == RST_ACT) begin
      r_state     <= ST_IDLE;
      r_prevReady <= 1'b0;
      r_enable    <= 1'b0;
      r_txEnable  <= 1'b0;
      r_running   <= 1'b0;
      r_divisor   <= '0;
      r_ovs       <= '0;
    end else begin
      r_prevReady <= bus.isReady;
      if (w_capture) begin
        r_divisor <= w_newDiv;
        r_state   <= w_newNonZero ? ST_RUN : ST_IDLE;
      end
      r_running  <= w_runNext;
      r_enable   <= w_enableNext;
      r_txEnable <= w_enableNext && (w_ovsBase == OVS_MAX);
      r_ovs      <= w_enableNext ? (w_ovsBase + OVS_W'(1)) : w_ovsBase;
    end
  end

  assign bus.enable   = r_enable;
  assign bus.txEnable = r_txEnable;
  assign bus.running  = r_running;
  assign bus.divisor  = r_divisor;

endmodule
`default_nettype wire

// File: tb/tb_spart_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_spart_baud_gen
// Brief    : Directed self-checking bench for spart_baud_gen.
// Revision : 1.0
// ============================================================================
module tb_spart_baud_gen;

  logic clk;
  logic rst;
  int   nChecks;
  int   nFails;

  spart_baud_gen_if #(.DIV_WIDTH(16)) bus ();

  spart_baud_gen #(
    .DIV_WIDTH  (16),
    .OVERSAMPLE (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench sampling cycle 1 after the capture edge.
  task automatic capture(input logic [15:0] d);
    if (bus.isReady) begin
      bus.isReady = 1'b0;
      step();
    end
    bus.dbHigh  = d[15:8];
    bus.dbLow   = d[7:0];
    bus.isReady = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst         = 1'b0;
    bus.dbHigh  = 8'h00;
    bus.dbLow   = 8'h05;
    bus.isReady = 1'b1;
    step();
    step();
    nChecks++;
    if (bus.enable !== 1'b0) begin
      nFails++; $display("FAIL reset enable got %b exp 0", bus.enable);
    end
    nChecks++;
    if (bus.txEnable !== 1'b0) begin
      nFails++; $display("FAIL reset txEnable got %b exp 0", bus.txEnable);
    end
    nChecks++;
    if (bus.running !== 1'b0) begin
      nFails++; $display("FAIL reset running got %b exp 0", bus.running);
    end
    nChecks++;
    if (bus.divisor !== 16'h0000) begin
      nFails++; $display("FAIL reset divisor got %h exp 0000", bus.divisor);
    end
    bus.isReady = 1'b0;
    step();
    rst = 1'b1;
    step();
    nChecks++;
    if (bus.running !== 1'b0) begin
      nFails++; $display("FAIL reset_release running got %b exp 0", bus.running);
    end
  endtask

  task automatic test_div4();
    capture(16'h0004);
    nChecks++;
    if (bus.running !== 1'b1) begin
      nFails++; $display("FAIL div4 running got %b exp 1", bus.running);
    end
    nChecks++;
    if (bus.divisor !== 16'h0004) begin
      nFails++; $display("FAIL div4 divisor got %h exp 0004", bus.divisor);
    end
    for (int k = 1; k <= 70; k++) begin
      nChecks++;
      if (bus.enable !== ((k % 4) == 0)) begin
        nFails++; $display("FAIL div4 enable k=%0d got %b exp %b", k, bus.enable, (k % 4) == 0);
      end
      nChecks++;
      if (bus.txEnable !== ((k % 64) == 0)) begin
        nFails++; $display("FAIL div4 txEnable k=%0d got %b exp %b", k, bus.txEnable, (k % 64) == 0);
      end
      step();
    end
  endtask

  task automatic test_div1();
    capture(16'h0001);
    for (int k = 1; k <= 40; k++) begin
      nChecks++;
      if (bus.enable !== 1'b1) begin
        nFails++; $display("FAIL div1 enable k=%0d got %b exp 1", k, bus.enable);
      end
      nChecks++;
      if (bus.txEnable !== ((k % 16) == 0)) begin
        nFails++; $display("FAIL div1 txEnable k=%0d got %b exp %b", k, bus.txEnable, (k % 16) == 0);
      end
      step();
    end
  endtask

  task automatic test_restart();
    capture(16'h0004);
    for (int k = 1; k < 22; k++) step();
    bus.isReady = 1'b0;
    step();
    capture(16'h0003);
    nChecks++;
    if (bus.divisor !== 16'h0003) begin
      nFails++; $display("FAIL restart divisor got %h exp 0003", bus.divisor);
    end
    for (int k = 1; k <= 50; k++) begin
      nChecks++;
      if (bus.enable !== ((k % 3) == 0)) begin
        nFails++; $display("FAIL restart enable k=%0d got %b exp %b", k, bus.enable, (k % 3) == 0);
      end
      nChecks++;
      if (bus.txEnable !== (k == 48)) begin
        nFails++; $display("FAIL restart txEnable k=%0d got %b exp %b", k, bus.txEnable, k == 48);
      end
      step();
    end
  endtask

  task automatic test_stop();
    capture(16'h0000);
    nChecks++;
    if (bus.running !== 1'b0) begin
      nFails++; $display("FAIL stop running got %b exp 0", bus.running);
    end
    nChecks++;
    if (bus.divisor !== 16'h0000) begin
      nFails++; $display("FAIL stop divisor got %h exp 0000", bus.divisor);
    end
    for (int k = 1; k <= 20; k++) begin
      nChecks++;
      if ({bus.enable, bus.txEnable} !== 2'b00) begin
        nFails++; $display("FAIL stop ticks k=%0d got %b%b exp 00", k, bus.enable, bus.txEnable);
      end
      step();
    end
  endtask

  task automatic test_mid_reset();
    capture(16'h00FF);
    for (int k = 1; k <= 10; k++) step();
    rst         = 1'b0;
    bus.isReady = 1'b0;
    step();
    nChecks++;
    if ({bus.enable, bus.txEnable, bus.running} !== 3'b000) begin
      nFails++; $display("FAIL midreset flags got %b%b%b exp 000", bus.enable, bus.txEnable, bus.running);
    end
    nChecks++;
    if (bus.divisor !== 16'h0000) begin
      nFails++; $display("FAIL midreset divisor got %h exp 0000", bus.divisor);
    end
    rst = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      step();
      nChecks++;
      if ({bus.enable, bus.running} !== 2'b00) begin
        nFails++; $display("FAIL postreset idle k=%0d got %b%b exp 00", k, bus.enable, bus.running);
      end
    end
    capture(16'h0002);
    nChecks++;
    if (bus.divisor !== 16'h0002) begin
      nFails++; $display("FAIL recapture divisor got %h exp 0002", bus.divisor);
    end
    for (int k = 1; k <= 8; k++) begin
      nChecks++;
      if (bus.enable !== ((k % 2) == 0)) begin
        nFails++; $display("FAIL recapture enable k=%0d got %b exp %b", k, bus.enable, (k % 2) == 0);
      end
      step();
    end
  endtask

  initial begin
    nChecks     = 0;
    nFails      = 0;
    rst         = 1'b0;
    bus.dbLow   = 8'h00;
    bus.dbHigh  = 8'h00;
    bus.isReady = 1'b0;
    test_reset();
    test_div4();
    test_div1();
    test_restart();
    test_stop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
`default_nettype wire
